riscv_aes_controller: RTL and testbench

Sequencer for the RISC-V AES extension. It sits between the AES register file (plaintext/key/write-back-address registers plus start flag) and the AES round core. On a start request it snapshots the block and key and launches the core. It then waits for completion and writes the 128-bit result back to data memory as four 32-bit stores over the core's OBI-style request/grant data port.

---
 rtl/riscv_aes_controller.sv | 202 ++++++++++++++++++++
 tb/tb_riscv_aes_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_aes_controller.sv
// AES extension sequencer: snapshots operands, launches the round core and
// writes the 128-bit result back as four stores. Optional: RISCV_AES_TIMEOUT_EN.
module riscv_aes_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    aes_start_i,
  input  logic [DATA_WIDTH-1:0]   block_a_i,
  input  logic [DATA_WIDTH-1:0]   block_b_i,
  input  logic [DATA_WIDTH-1:0]   block_c_i,
  input  logic [DATA_WIDTH-1:0]   block_d_i,
  input  logic [DATA_WIDTH-1:0]   key_a_i,
  input  logic [DATA_WIDTH-1:0]   key_b_i,
  input  logic [DATA_WIDTH-1:0]   key_c_i,
  input  logic [DATA_WIDTH-1:0]   key_d_i,
  input  logic [31:0]             wb_addr_i,
  output logic                    core_start_o,
  output logic [4*DATA_WIDTH-1:0] core_block_o,
  output logic [4*DATA_WIDTH-1:0] core_key_o,
  input  logic                    core_done_i,
  input  logic [4*DATA_WIDTH-1:0] core_result_i,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [31:0]             data_addr_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("riscv_aes_controller: unsupported parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WB,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    start_prev_q, start_prev_d;
  logic [4*DATA_WIDTH-1:0] block_q, block_d;
  logic [4*DATA_WIDTH-1:0] key_q, key_d;
  logic [4*DATA_WIDTH-1:0] result_q, result_d;
  logic [29:0]             base_q, base_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              idx_n;
  logic                    core_start_q, core_start_d;
  logic                    req_q, req_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    start_rise;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^wb_addr_i[1:0];
  assign start_rise      = aes_start_i & ~start_prev_q;
  assign idx_n           = idx_q + 2'd1;

`ifdef RISCV_AES_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
`endif

  always_comb begin
    state_d      = state_q;
    start_prev_d = aes_start_i;
    block_d      = block_q;
    key_d        = key_q;
    result_d     = result_q;
    base_d       = base_q;
    idx_d        = idx_q;
    core_start_d = 1'b0;
    req_d        = req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
`ifdef RISCV_AES_TIMEOUT_EN
    cnt_d        = cnt_q;
    error_d      = error_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d      = S_RUN;
          block_d      = {block_d_i, block_c_i, block_b_i, block_a_i};
          key_d        = {key_d_i, key_c_i, key_b_i, key_a_i};
          base_d       = wb_addr_i[31:2];
          core_start_d = 1'b1;
`ifdef RISCV_AES_TIMEOUT_EN
          cnt_d        = '0;
          error_d      = 1'b0;
`endif
        end
      end
      S_RUN: begin
        // done in the launch cycle belongs to a stale op; ignore it
        if (core_done_i && !core_start_q) begin
          state_d  = S_WB;
          result_d = core_result_i;
          idx_d    = 2'd0;
          req_d    = 1'b1;
          addr_d   = {base_q, 2'b00};
          wdata_d  = core_result_i[DATA_WIDTH-1:0];
        end
`ifdef RISCV_AES_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WB: begin
        if (data_gnt_i) begin
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_n;
            addr_d  = addr_q + 32'd4;
            wdata_d = result_q[{idx_n, 5'd0} +: DATA_WIDTH];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      block_q      <= '0;
      key_q        <= '0;
      result_q     <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      core_start_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
`ifdef RISCV_AES_TIMEOUT_EN
      cnt_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      block_q      <= block_d;
      key_q        <= key_d;
      result_q     <= result_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      core_start_q <= core_start_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
`ifdef RISCV_AES_TIMEOUT_EN
      cnt_q        <= cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  assign core_start_o = core_start_q;
  assign core_block_o = block_q;
  assign core_key_o   = key_q;
  assign data_req_o   = req_q;
  assign data_we_o    = req_q;
  assign data_be_o    = {4{req_q}};
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;

`ifdef RISCV_AES_TIMEOUT_EN
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_aes_controller.sv
// Randomized bench for riscv_aes_controller against a behavioural
// model of the start/run/write-back sequence.
module tb_riscv_aes_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         aes_start_i;
  logic [31:0]  block_a_i, block_b_i, block_c_i, block_d_i;
  logic [31:0]  key_a_i, key_b_i, key_c_i, key_d_i;
  logic [31:0]  wb_addr_i;
  logic         core_start_o;
  logic [127:0] core_block_o, core_key_o;
  logic         core_done_i;
  logic [127:0] core_result_i;
  logic         data_req_o, data_gnt_i;
  logic [31:0]  data_addr_o, data_wdata_o;
  logic         data_we_o;
  logic [3:0]   data_be_o;
  logic         busy_o, done_o, error_o;

  always #5 clk = ~clk;

  riscv_aes_controller #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .aes_start_i(aes_start_i),
    .block_a_i(block_a_i), .block_b_i(block_b_i),
    .block_c_i(block_c_i), .block_d_i(block_d_i),
    .key_a_i(key_a_i), .key_b_i(key_b_i),
    .key_c_i(key_c_i), .key_d_i(key_d_i),
    .wb_addr_i(wb_addr_i),
    .core_start_o(core_start_o), .core_block_o(core_block_o),
    .core_key_o(core_key_o), .core_done_i(core_done_i),
    .core_result_i(core_result_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int exp_starts = 0;
  logic [31:0] blk[4];
  logic [31:0] key[4];

  always @(posedge clk) if (core_start_o) starts++;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    {block_a_i, block_b_i, block_c_i, block_d_i} = {blk[0], blk[1], blk[2], blk[3]};
    {key_a_i, key_b_i, key_c_i, key_d_i} = {key[0], key[1], key[2], key[3]};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 128'(data_req_o), 0);
    check({tag, "_busy"}, 128'(busy_o), 0);
    check({tag, "_outs"}, 128'({core_start_o, done_o, error_o,
                                data_we_o, data_be_o}), 0);
    check({tag, "_addr"}, 128'({data_addr_o, data_wdata_o}), 0);
    check({tag, "_blk"}, core_block_o, 0);
    check({tag, "_key"}, core_key_o, 0);
  endtask

  // One operation: start edge, optional early done, core done after dly,
  // grants with 0..maxd wait; reset after stop_after grants if < 4.
  task automatic run_op(input logic [31:0] base, input bit rnd,
                        input int dly, input int maxd, input bit early,
                        input bit toggle, input bit keep_high,
                        input int stop_after);
    logic [127:0] res;
    logic [31:0]  ea;
    int n;
    int w;
    int budget;
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        blk[i] = $urandom;
        key[i] = $urandom;
      end
    end
    drive_ops();
    res = {$urandom, $urandom, $urandom, $urandom};
    wb_addr_i = base;
    aes_start_i = 1'b1;
    step();
    exp_starts++;
    check("start_pulse", 128'(core_start_o), 1);
    check("busy_run", 128'(busy_o), 1);
    check("err_clear", 128'(error_o), 0);
    check("blk_latch", core_block_o, {blk[3], blk[2], blk[1], blk[0]});
    check("key_latch", core_key_o, {key[3], key[2], key[1], key[0]});
    {block_a_i, block_b_i, block_c_i, block_d_i} = {$urandom, $urandom, $urandom, $urandom};
    {key_a_i, key_b_i, key_c_i, key_d_i} = {$urandom, $urandom, $urandom, $urandom};
    wb_addr_i = $urandom;
    if (early) begin
      core_done_i = 1'b1;
      core_result_i = ~res;
    end
    step();
    core_done_i = 1'b0;
    check("pulse_once", 128'(core_start_o), 0);
    check("no_req_run", 128'(data_req_o), 0);
    check("blk_hold", core_block_o, {blk[3], blk[2], blk[1], blk[0]});
    if (toggle) begin
      aes_start_i = 1'b0;
      step();
      aes_start_i = 1'b1;
    end
    if (!keep_high) aes_start_i = 1'b0;
    repeat (dly) step();
    check("still_run", 128'({busy_o, data_req_o}), 128'(2'b10));
    core_done_i = 1'b1;
    core_result_i = res;
    step();
    core_done_i = 1'b0;
    core_result_i = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    w = $urandom_range(0, maxd);
    budget = 200;
    while (n < 4 && n != stop_after && budget > 0) begin
      ea = {base[31:2], 2'b00} + 32'(4 * n);
      check("req", 128'(data_req_o), 1);
      check("addr", 128'(data_addr_o), 128'(ea));
      check("wdata", 128'(data_wdata_o), 128'(res[32*n +: 32]));
      check("we_be", 128'({data_we_o, data_be_o}), 128'(5'h1F));
      data_gnt_i = (w == 0);
      step();
      if (data_gnt_i) begin
        n++;
        w = $urandom_range(0, maxd);
      end else begin
        w--;
      end
      data_gnt_i = 1'b0;
      budget--;
    end
    if (stop_after < 4) begin
      check("grants_pre_rst", 128'(n), 128'(stop_after));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_all_zero("rst_wb");
      repeat (3) begin
        step();
        check("no_req_after_rst", 128'({data_req_o, busy_o}), 0);
      end
    end else begin
      check("grants", 128'(n), 4);
      check("done_pulse", 128'(done_o), 1);
      check("req_off", 128'(data_req_o), 0);
      check("busy_done", 128'(busy_o), 1);
      check("err_none", 128'(error_o), 0);
      step();
      check("done_once", 128'(done_o), 0);
      check("idle", 128'(busy_o), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    aes_start_i = 1'b0;
    core_done_i = 1'b0;
    core_result_i = '0;
    data_gnt_i = 1'b0;
    wb_addr_i = '0;
    for (int i = 0; i < 4; i++) begin
      blk[i] = $urandom;
      key[i] = $urandom;
    end
    drive_ops();
    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    blk[0] = 32'h00112233; blk[1] = 32'h44556677;
    blk[2] = 32'h8899aabb; blk[3] = 32'hccddeeff;
    run_op(32'h1000_0003, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 4);

    run_op($urandom, 1'b1, 4, 2, 1'b1, 1'b1, 1'b1, 4);
    repeat (5) begin
      step();
      check("hold_no_retrig", 128'(busy_o), 0);
    end
    check("start_count", 128'(starts), 128'(exp_starts));
    aes_start_i = 1'b0;
    step();
    run_op($urandom, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 4);

    run_op(32'hFFFF_FFF8, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0, 4);

    run_op($urandom, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 2);
    run_op($urandom, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0, 4);

`ifdef RISCV_AES_TIMEOUT_EN
    begin
      int cyc;
      aes_start_i = 1'b1;
      step();
      exp_starts++;
      aes_start_i = 1'b0;
      check("to_pulse", 128'(core_start_o), 1);
      cyc = 1;
      while (!done_o && cyc < 100) begin
        check("to_noreq", 128'(data_req_o), 0);
        step();
        cyc++;
      end
      check("to_cycles", 128'(cyc), 17);
      check("to_error", 128'(error_o), 1);
      step();
      check("to_idle", 128'({busy_o, error_o}), 128'(2'b01));
    end
`endif

    repeat (6) begin
      logic [31:0] b;
      b = $urandom;
      run_op(b, 1'b1, $urandom_range(0, 8), 5, 1'($urandom_range(0, 1)),
             1'b0, 1'b0, 4);
    end
    check("start_total", 128'(starts), 128'(exp_starts));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
